// File: rtl/etroc2_pixel_pkg.sv
// Shared field widths and hit-entry packing for the ETROC2 pixel storage stage.
// Entries are packed {hit, err, TOA, TOT, Cal} with hit as the MSB.
package etroc2_pixel_pkg;

  localparam int TOA_W   = 10;
  localparam int TOT_W   = 9;
  localparam int CAL_W   = 10;
  localparam int ERR_W   = 3;
  localparam int ENTRY_W = 1 + ERR_W + TOA_W + TOT_W + CAL_W;
  localparam int DATA_W  = ENTRY_W - 1;

  typedef struct packed {
    logic             hit;
    logic [ERR_W-1:0] err;
    logic [TOA_W-1:0] toa;
    logic [TOT_W-1:0] tot;
    logic [CAL_W-1:0] cal;
  } hit_entry_t;

  // Non-hit entries carry all-zero payload so stale codes never leak downstream.
  function automatic hit_entry_t pack_entry(
    input logic             hit,
    input logic [ERR_W-1:0] err,
    input logic [TOA_W-1:0] toa,
    input logic [TOT_W-1:0] tot,
    input logic [CAL_W-1:0] cal
  );
    hit_entry_t e;
    if (hit) begin
      e.hit = 1'b1;
      e.err = err;
      e.toa = toa;
      e.tot = tot;
      e.cal = cal;
    end else begin
      e = {ENTRY_W{1'b0}};
    end
    return e;
  endfunction

endpackage

// File: rtl/pixel_hit_buffer_hit_fifo.sv
// Parameterised synchronous FIFO with synchronous active-low reset.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module hit_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_en_s;
  logic             pop_en_s;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_en_s  = pop & ~empty;
    push_en_s = push & (~full | pop_en_s);
    rd_data   = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer update
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_en_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_en_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset because empty gates every read
  always_ff @(posedge clk) begin
    if (push_en_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pixel_hit_buffer.sv
// Per-pixel circular hit buffer written every BX, read back on L1A at the
// programmed latency; triggered hits are queued with their L1 ID for readout.
module pixel_hit_buffer
  import etroc2_pixel_pkg::*;
#(
  parameter int CB_DEPTH   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int L1ID_W     = 8,
  parameter int CB_AW      = $clog2(CB_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TOA_W-1:0]  TOA_code,
  input  logic [TOT_W-1:0]  TOT_code,
  input  logic [CAL_W-1:0]  Cal_code,
  input  logic              hitFlag,
  input  logic [ERR_W-1:0]  errFlags,
  input  logic              disPixel,
  input  logic              L1A,
  input  logic [CB_AW-1:0]  latency,
  output logic              hitValid,
  input  logic              hitReady,
  output logic [TOA_W-1:0]  hitTOA,
  output logic [TOT_W-1:0]  hitTOT,
  output logic [CAL_W-1:0]  hitCal,
  output logic [ERR_W-1:0]  hitErr,
  output logic [L1ID_W-1:0] hitL1Id,
  output logic [L1ID_W-1:0] l1Id,
  output logic              overflow,
  output logic [7:0]        dropCount
);

  localparam int FIFO_W = DATA_W + L1ID_W;

  hit_entry_t        cb_mem_r [CB_DEPTH];
  logic [CB_AW-1:0]  wr_ptr_r;
  logic [CB_AW-1:0]  lat_eff_s;
  logic [CB_AW-1:0]  rd_addr_s;
  hit_entry_t        wr_entry_s;
  hit_entry_t        rd_entry_s;
  logic [L1ID_W-1:0] l1_id_r;
  logic              overflow_r;
  logic [7:0]        drop_count_r;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [FIFO_W-1:0] fifo_wr_data_s;
  logic [FIFO_W-1:0] fifo_rd_data_s;

  // Write-entry formation, latency-addressed read and FIFO handshake terms
  always_comb begin
    wr_entry_s = pack_entry(hitFlag & ~disPixel, errFlags, TOA_code, TOT_code, Cal_code);
    if (latency == {CB_AW{1'b0}}) begin
      lat_eff_s = CB_AW'(1);
    end else begin
      lat_eff_s = latency;
    end
    rd_addr_s      = wr_ptr_r - lat_eff_s;
    rd_entry_s     = cb_mem_r[rd_addr_s];
    push_s         = reset & L1A & rd_entry_s.hit;
    pop_s          = reset & ~fifo_empty_s & hitReady;
    drop_s         = push_s & fifo_full_s & ~pop_s;
    fifo_wr_data_s = {rd_entry_s.err, rd_entry_s.toa, rd_entry_s.tot, rd_entry_s.cal, l1_id_r};
  end

  // Circular buffer write; reset only needs to invalidate the hit bits
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {CB_AW{1'b0}};
      for (int i = 0; i < CB_DEPTH; i++) begin
        cb_mem_r[i].hit <= 1'b0;
      end
    end else begin
      cb_mem_r[wr_ptr_r] <= wr_entry_s;
      wr_ptr_r           <= wr_ptr_r + CB_AW'(1);
    end
  end

  // Trigger counter and sticky drop bookkeeping
  always_ff @(posedge clk) begin
    if (!reset) begin
      l1_id_r      <= {L1ID_W{1'b0}};
      overflow_r   <= 1'b0;
      drop_count_r <= 8'd0;
    end else begin
      if (L1A) l1_id_r <= l1_id_r + L1ID_W'(1);
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_count_r != 8'd255) drop_count_r <= drop_count_r + 8'd1;
      end
    end
  end

  hit_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_hit_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (fifo_wr_data_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Head fields are forced to zero whenever nothing is queued
  always_comb begin
    hitValid = ~fifo_empty_s;
    if (hitValid) begin
      {hitErr, hitTOA, hitTOT, hitCal, hitL1Id} = fifo_rd_data_s;
    end else begin
      hitErr  = {ERR_W{1'b0}};
      hitTOA  = {TOA_W{1'b0}};
      hitTOT  = {TOT_W{1'b0}};
      hitCal  = {CAL_W{1'b0}};
      hitL1Id = {L1ID_W{1'b0}};
    end
  end

  assign l1Id      = l1_id_r;
  assign overflow  = overflow_r;
  assign dropCount = drop_count_r;

endmodule

// File: tb/tb_pixel_hit_buffer.sv
// Directed self-checking bench for pixel_hit_buffer: latency readout, masking,
// wrap-around, overflow, full-with-pop and mid-readout reset.
module tb_pixel_hit_buffer;

  logic       clk;
  logic       reset;
  logic [9:0] TOA_code;
  logic [8:0] TOT_code;
  logic [9:0] Cal_code;
  logic       hitFlag;
  logic [2:0] errFlags;
  logic       disPixel;
  logic       L1A;
  logic [3:0] latency;
  logic       hitValid;
  logic       hitReady;
  logic [9:0] hitTOA;
  logic [8:0] hitTOT;
  logic [9:0] hitCal;
  logic [2:0] hitErr;
  logic [7:0] hitL1Id;
  logic [7:0] l1Id;
  logic       overflow;
  logic [7:0] dropCount;

  int total = 0;
  int bad   = 0;

  pixel_hit_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .TOA_code  (TOA_code),
    .TOT_code  (TOT_code),
    .Cal_code  (Cal_code),
    .hitFlag   (hitFlag),
    .errFlags  (errFlags),
    .disPixel  (disPixel),
    .L1A       (L1A),
    .latency   (latency),
    .hitValid  (hitValid),
    .hitReady  (hitReady),
    .hitTOA    (hitTOA),
    .hitTOT    (hitTOT),
    .hitCal    (hitCal),
    .hitErr    (hitErr),
    .hitL1Id   (hitL1Id),
    .l1Id      (l1Id),
    .overflow  (overflow),
    .dropCount (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_codes(input logic [9:0] toa, input logic [8:0] tot, input logic [9:0] cal,
                           input logic [2:0] err);
    TOA_code = toa;
    TOT_code = tot;
    Cal_code = cal;
    errFlags = err;
  endtask

  task automatic chk_head(input string tag, input logic [9:0] toa, input logic [8:0] tot,
                          input logic [9:0] cal, input logic [2:0] err, input logic [7:0] id);
    chk({tag, "_valid"}, 40'(hitValid), 40'(1'b1));
    chk({tag, "_toa"},   40'(hitTOA),   40'(toa));
    chk({tag, "_tot"},   40'(hitTOT),   40'(tot));
    chk({tag, "_cal"},   40'(hitCal),   40'(cal));
    chk({tag, "_err"},   40'(hitErr),   40'(err));
    chk({tag, "_id"},    40'(hitL1Id),  40'(id));
  endtask

  initial begin
    reset    = 1'b0;
    hitFlag  = 1'b0;
    disPixel = 1'b0;
    L1A      = 1'b0;
    hitReady = 1'b0;
    latency  = 4'd5;
    set_codes(10'h000, 9'h000, 10'h000, 3'b000);
    tick();
    tick();

    // Reset state
    chk("rst_valid", 40'(hitValid),  40'(1'b0));
    chk("rst_l1id",  40'(l1Id),      40'(8'd0));
    chk("rst_ovf",   40'(overflow),  40'(1'b0));
    chk("rst_drop",  40'(dropCount), 40'(8'd0));
    chk("rst_toa",   40'(hitTOA),    40'(10'h000));

    // Latency readout: hit at BX 10, L1A at BX 15 with latency 5
    reset = 1'b1;                       // cycle 0
    repeat (10) tick();                 // cycle 10
    hitFlag = 1'b1;
    set_codes(10'h155, 9'h0AA, 10'h2A3, 3'b000);
    tick();                             // cycle 11
    hitFlag = 1'b0;
    set_codes(10'h000, 9'h000, 10'h000, 3'b000);
    repeat (4) tick();                  // cycle 15
    L1A = 1'b1;
    chk("lat_pre_valid", 40'(hitValid), 40'(1'b0));
    tick();                             // cycle 16
    L1A = 1'b0;
    chk_head("lat", 10'h155, 9'h0AA, 10'h2A3, 3'b000, 8'd0);
    chk("lat_l1id", 40'(l1Id), 40'(8'd1));
    hitReady = 1'b1;
    tick();                             // cycle 17
    hitReady = 1'b0;
    chk("lat_popped", 40'(hitValid), 40'(1'b0));

    // Non-hit entry: L1A at cycle 17 reads BX 12 which held no hit
    L1A = 1'b1;
    tick();                             // cycle 18
    L1A = 1'b0;
    chk("nohit_valid", 40'(hitValid), 40'(1'b0));
    chk("nohit_l1id",  40'(l1Id),     40'(8'd2));

    // Disabled pixel: hit written at cycle 18 (wrPtr 2), triggered at cycle 23
    hitFlag  = 1'b1;
    disPixel = 1'b1;
    set_codes(10'h3C3, 9'h111, 10'h0F0, 3'b111);
    tick();                             // cycle 19
    hitFlag  = 1'b0;
    disPixel = 1'b0;
    set_codes(10'h000, 9'h000, 10'h000, 3'b000);
    repeat (4) tick();                  // cycle 23
    L1A = 1'b1;
    tick();                             // cycle 24
    L1A = 1'b0;
    chk("dis_valid", 40'(hitValid), 40'(1'b0));
    chk("dis_l1id",  40'(l1Id),     40'(8'd3));

    // Wrap-around: latency 15, hit at wrPtr 14 (cycle 30), L1A at wrPtr 13 (cycle 45)
    latency = 4'd15;
    repeat (6) tick();                  // cycle 30
    hitFlag = 1'b1;
    set_codes(10'h0F0, 9'h1FF, 10'h001, 3'b101);
    tick();                             // cycle 31
    hitFlag = 1'b0;
    set_codes(10'h000, 9'h000, 10'h000, 3'b000);
    repeat (14) tick();                 // cycle 45
    L1A = 1'b1;
    tick();                             // cycle 46
    L1A = 1'b0;
    chk_head("wrap", 10'h0F0, 9'h1FF, 10'h001, 3'b101, 8'd3);
    chk("wrap_l1id", 40'(l1Id), 40'(8'd4));
    hitReady = 1'b1;
    tick();
    hitReady = 1'b0;

    // Fresh start for the overflow scenario
    reset = 1'b0;
    tick();
    reset = 1'b1;                       // cycle 0
    chk("rst2_l1id", 40'(l1Id), 40'(8'd0));

    // Overflow: latency 0 behaves as 1; hits at BX 0..7, L1A at cycles 1..6
    latency = 4'd0;
    for (int i = 0; i < 8; i++) begin
      hitFlag = 1'b1;
      set_codes(10'(16 + i), 9'(32 + i), 10'(64 + i), 3'(i));
      L1A = (i >= 1 && i <= 6);
      tick();
    end                                 // cycle 8
    hitFlag = 1'b0;
    L1A     = 1'b0;
    set_codes(10'h000, 9'h000, 10'h000, 3'b000);
    chk("ovf_flag", 40'(overflow),  40'(1'b1));
    chk("ovf_drop", 40'(dropCount), 40'(8'd2));
    chk("ovf_l1id", 40'(l1Id),      40'(8'd6));
    chk_head("ovf_h0", 10'd16, 9'd32, 10'd64, 3'd0, 8'd0);
    tick();                             // cycle 9: head held while not ready
    chk_head("hold_h0", 10'd16, 9'd32, 10'd64, 3'd0, 8'd0);

    // Full with simultaneous push and pop: latency 2 reads BX 7
    latency  = 4'd2;
    L1A      = 1'b1;
    hitReady = 1'b1;
    tick();                             // cycle 10
    L1A = 1'b0;
    chk("fullpop_drop", 40'(dropCount), 40'(8'd2));
    chk("fullpop_l1id", 40'(l1Id),      40'(8'd7));
    chk_head("drain1", 10'd17, 9'd33, 10'd65, 3'd1, 8'd1);
    tick();
    chk_head("drain2", 10'd18, 9'd34, 10'd66, 3'd2, 8'd2);
    tick();
    chk_head("drain3", 10'd19, 9'd35, 10'd67, 3'd3, 8'd3);
    tick();
    chk_head("drain4", 10'd23, 9'd39, 10'd71, 3'd7, 8'd6);
    tick();                             // cycle 14
    chk("drain_empty", 40'(hitValid), 40'(1'b0));

    // Reset mid-readout: queue three hits, then reset with an L1A pending
    hitReady = 1'b0;
    latency  = 4'd1;
    for (int i = 0; i < 4; i++) begin
      hitFlag = (i < 3);
      set_codes(10'(100 + i), 9'(200 + i), 10'(300 + i), 3'b010);
      L1A = (i >= 1);
      tick();
    end                                 // cycle 18
    hitFlag = 1'b0;
    L1A     = 1'b0;
    set_codes(10'h000, 9'h000, 10'h000, 3'b000);
    chk_head("q3_h0", 10'd100, 9'd200, 10'd300, 3'b010, 8'd7);
    chk("q3_ovf",  40'(overflow), 40'(1'b1));
    chk("q3_l1id", 40'(l1Id),     40'(8'd10));
    reset = 1'b0;
    L1A   = 1'b1;
    tick();
    reset = 1'b1;
    chk("mrst_valid", 40'(hitValid),  40'(1'b0));
    chk("mrst_ovf",   40'(overflow),  40'(1'b0));
    chk("mrst_drop",  40'(dropCount), 40'(8'd0));
    chk("mrst_l1id",  40'(l1Id),      40'(8'd0));
    chk("mrst_toa",   40'(hitTOA),    40'(10'h000));
    tick();                             // L1A on first cycle after reset
    L1A = 1'b0;
    chk("post_valid", 40'(hitValid), 40'(1'b0));
    chk("post_l1id",  40'(l1Id),     40'(8'd1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
